multi_mode_stopwatch: RTL and testbench

MULTI_MODE_STOPWATCH -- requirements
Module: multi_mode_stopwatch

---
 rtl/multi_mode_stopwatch_pkg.sv | 28 ++
 rtl/multi_mode_stopwatch_lap_fifo.sv | 77 +++++++
 rtl/multi_mode_stopwatch.sv | 152 +++++++++++++++
 tb/tb_multi_mode_stopwatch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_mode_stopwatch_pkg.sv
// Shared types and constants for the multi-mode stopwatch: FSM states,
// the packed time record and the per-field widths and limits.
package multi_mode_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int HR_W   = 5;
  localparam int MN_W   = 6;
  localparam int SC_W   = 6;
  localparam int CS_W   = 7;
  localparam int TIME_W = HR_W + MN_W + SC_W + CS_W;

  localparam logic [SC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MN_W-1:0] MIN_MAX = 6'd59;

  // Same bit layout as i_load_time / o_lap_time: {hour, min, sec, centisec}.
  typedef struct packed {
    logic [HR_W-1:0] hr;
    logic [MN_W-1:0] mn;
    logic [SC_W-1:0] sc;
    logic [CS_W-1:0] cs;
  } time_t;

endpackage

// File: rtl/multi_mode_stopwatch_lap_fifo.sv
// Lap buffer: small FIFO with a registered head-of-queue output and a
// synchronous flush. A push into a full buffer is dropped.
module lap_fifo
  import multi_mode_stopwatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [TIME_W-1:0] din,
  output logic [TIME_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TIME_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_q, rd_q, rd_nx;
  logic [CW-1:0]     count_d;
  logic              push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push && !clear && !full;
  assign pop_ok  = pop && !clear && (count != '0);
  assign rd_nx   = ptr_inc(rd_q);

  always_comb begin
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
      full  <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
      full  <= 1'b0;
      dout  <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= rd_nx;
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      // Head output follows the new oldest entry; a simultaneous push into a
      // one-entry buffer becomes the head directly since it is not in mem yet.
      if (pop_ok) begin
        if (count == CW'(1)) dout <= push_ok ? din : '0;
        else                 dout <= mem[rd_nx];
      end else if (push_ok && count == '0) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/multi_mode_stopwatch.sv
// Up/down stopwatch with preset load, expiry on down-count to zero and a
// FIFO of captured lap times.
module multi_mode_stopwatch
  import multi_mode_stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOUR_MOD  = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic                           i_runstop,
  input  logic                           i_dir,
  input  logic                           i_load,
  input  logic [23:0]                    i_load_time,
  input  logic                           i_lap,
  input  logic                           i_lap_rd,
  output logic [6:0]                     msec,
  output logic [5:0]                     sec,
  output logic [5:0]                     min,
  output logic [4:0]                     hour,
  output logic                           o_running,
  output logic                           o_expired,
  output logic [23:0]                    o_lap_time,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_count,
  output logic                           o_lap_full
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [CS_W-1:0] CS_MAX = CS_W'(TICK_HZ - 1);
  localparam logic [HR_W-1:0] HR_MAX = HR_W'(HOUR_MOD - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  time_t         time_q, time_d, up_t, dn_t, sat_t, ld_t;
  logic          tick, at_zero, lap_push;

  assign ld_t     = time_t'(i_load_time);
  assign tick     = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
  assign at_zero  = (time_q == '0);
  assign lap_push = i_lap && (state_q != ST_EXPIRED);

  always_comb begin
    up_t = time_q;
    if (time_q.cs != CS_MAX) up_t.cs = time_q.cs + 1'b1;
    else begin
      up_t.cs = '0;
      if (time_q.sc != SEC_MAX) up_t.sc = time_q.sc + 1'b1;
      else begin
        up_t.sc = '0;
        if (time_q.mn != MIN_MAX) up_t.mn = time_q.mn + 1'b1;
        else begin
          up_t.mn = '0;
          up_t.hr = (time_q.hr == HR_MAX) ? '0 : time_q.hr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dn_t = time_q;
    if (time_q.cs != '0) dn_t.cs = time_q.cs - 1'b1;
    else begin
      dn_t.cs = CS_MAX;
      if (time_q.sc != '0) dn_t.sc = time_q.sc - 1'b1;
      else begin
        dn_t.sc = SEC_MAX;
        if (time_q.mn != '0) dn_t.mn = time_q.mn - 1'b1;
        else begin
          dn_t.mn = MIN_MAX;
          dn_t.hr = (time_q.hr == '0) ? HR_MAX : time_q.hr - 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat_t.cs = (ld_t.cs > CS_MAX)  ? CS_MAX  : ld_t.cs;
    sat_t.sc = (ld_t.sc > SEC_MAX) ? SEC_MAX : ld_t.sc;
    sat_t.mn = (ld_t.mn > MIN_MAX) ? MIN_MAX : ld_t.mn;
    sat_t.hr = (ld_t.hr > HR_MAX)  ? HR_MAX  : ld_t.hr;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    if (state_q == ST_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    if (i_clear) begin
      state_d = ST_STOP;
      presc_d = '0;
      time_d  = '0;
    end else if (i_load && state_q != ST_RUN) begin
      state_d = ST_STOP;
      presc_d = '0;
      time_d  = sat_t;
    end else begin
      if (i_runstop) begin
        if (state_q == ST_STOP)     state_d = ST_RUN;
        else if (state_q == ST_RUN) state_d = ST_STOP;
      end
      // Expiry wins over a same-cycle pause so a finished countdown is never lost.
      if (tick) begin
        if (!i_dir) time_d = up_t;
        else if (at_zero) state_d = ST_EXPIRED;
        else begin
          time_d = dn_t;
          if (dn_t == '0) state_d = ST_EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      time_q    <= '0;
      o_running <= 1'b0;
      o_expired <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      o_running <= (state_q == ST_RUN);
      o_expired <= (state_q == ST_EXPIRED);
    end
  end

  assign msec = time_q.cs;
  assign sec  = time_q.sc;
  assign min  = time_q.mn;
  assign hour = time_q.hr;

  lap_fifo #(
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .push  (lap_push),
    .pop   (i_lap_rd),
    .din   (time_q),
    .dout  (o_lap_time),
    .count (o_lap_count),
    .full  (o_lap_full)
  );

endmodule

// File: tb/tb_multi_mode_stopwatch.sv
// Directed bench for multi_mode_stopwatch: a vector table of load/run/check
// cases plus hand sequences for expiry, laps, priority, load-in-run and reset.
module tb_multi_mode_stopwatch;

  logic        clk, rst;
  logic        i_clear, i_runstop, i_dir, i_load, i_lap, i_lap_rd;
  logic [23:0] i_load_time;
  logic [6:0]  msec;
  logic [5:0]  sec, min;
  logic [4:0]  hour;
  logic        o_running, o_expired, o_lap_full;
  logic [23:0] o_lap_time;
  logic [2:0]  o_lap_count;

  int checks   = 0;
  int failures = 0;

  multi_mode_stopwatch #(
    .CLK_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24), .LAP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_runstop(i_runstop),
    .i_dir(i_dir), .i_load(i_load), .i_load_time(i_load_time),
    .i_lap(i_lap), .i_lap_rd(i_lap_rd), .msec(msec), .sec(sec), .min(min),
    .hour(hour), .o_running(o_running), .o_expired(o_expired),
    .o_lap_time(o_lap_time), .o_lap_count(o_lap_count), .o_lap_full(o_lap_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] tm(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [23:0] cur_time();
    return {hour, min, sec, msec};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
  endtask

  task automatic pulse_runstop();
    i_runstop = 1'b1; @(negedge clk); i_runstop = 1'b0;
  endtask

  task automatic pulse_lap();
    i_lap = 1'b1; @(negedge clk); i_lap = 1'b0;
  endtask

  task automatic pulse_pop();
    i_lap_rd = 1'b1; @(negedge clk); i_lap_rd = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] t);
    i_load_time = t; i_load = 1'b1; @(negedge clk); i_load = 1'b0;
  endtask

  typedef struct {
    logic [23:0] ld;
    logic        dir;
    int          ticks;
    logic [23:0] exp_t;
    logic        exp_run;
    logic        exp_exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    {i_clear, i_runstop, i_dir, i_load, i_lap, i_lap_rd} = '0;
    i_load_time = '0;

    vecs[0] = '{tm(0,0,59,99),   1'b0, 1, tm(0,1,0,0),    1'b1, 1'b0};
    vecs[1] = '{tm(23,59,59,99), 1'b0, 1, tm(0,0,0,0),    1'b1, 1'b0};
    vecs[2] = '{tm(0,0,0,2),     1'b1, 2, tm(0,0,0,0),    1'b0, 1'b1};
    vecs[3] = '{tm(0,1,0,0),     1'b1, 1, tm(0,0,59,99),  1'b1, 1'b0};
    vecs[4] = '{tm(1,0,0,0),     1'b1, 1, tm(0,59,59,99), 1'b1, 1'b0};
    vecs[5] = '{tm(31,63,63,127),1'b0, 0, tm(23,59,59,99),1'b1, 1'b0};
    vecs[6] = '{tm(0,0,0,0),     1'b1, 1, tm(0,0,0,0),    1'b0, 1'b1};
    vecs[7] = '{tm(0,0,0,5),     1'b0, 3, tm(0,0,0,8),    1'b1, 1'b0};

    cycles(3);
    check("rst_time",    32'(cur_time()),  32'(tm(0,0,0,0)));
    check("rst_running", 32'(o_running),   32'd0);
    check("rst_count",   32'(o_lap_count), 32'd0);
    check("rst_laptime", 32'(o_lap_time),  32'd0);
    rst = 1'b0;
    cycles(2);

    for (int v = 0; v < 8; v++) begin
      pulse_clear();
      i_dir = vecs[v].dir;
      do_load(vecs[v].ld);
      pulse_runstop();
      cycles(10 * vecs[v].ticks);
      $display("vector %0d: load=%06h dir=%0d ticks=%0d time=%06h", v,
               vecs[v].ld, vecs[v].dir, vecs[v].ticks, cur_time());
      check($sformatf("vec%0d_time", v), 32'(cur_time()), 32'(vecs[v].exp_t));
      cycles(1);
      check($sformatf("vec%0d_running", v), 32'(o_running), 32'(vecs[v].exp_run));
      check($sformatf("vec%0d_expired", v), 32'(o_expired), 32'(vecs[v].exp_exp));
      pulse_clear();
    end

    // Expiry holds the time at zero until cleared.
    i_dir = 1'b1;
    do_load(tm(0,0,0,2));
    pulse_runstop();
    cycles(20 + 30);
    $display("expiry hold: time=%06h expired=%0d", cur_time(), o_expired);
    check("exp_hold_time", 32'(cur_time()), 32'd0);
    check("exp_hold_flag", 32'(o_expired),  32'd1);
    check("exp_hold_run",  32'(o_running),  32'd0);
    pulse_clear();
    cycles(2);
    check("exp_clear_flag", 32'(o_expired), 32'd0);

    // Laps: captures at 0,1,2,3,4 centiseconds; the fifth is dropped.
    i_dir = 1'b0;
    do_load(tm(0,0,0,0));
    pulse_runstop();
    for (int k = 0; k < 5; k++) begin
      cycles(9);
      pulse_lap();
    end
    $display("laps pushed: count=%0d full=%0d", o_lap_count, o_lap_full);
    check("lap_count_full", 32'(o_lap_count), 32'd4);
    check("lap_full",       32'(o_lap_full),  32'd1);
    pulse_runstop();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lap_pop%0d_time", k),  32'(o_lap_time),  32'(tm(0,0,0,k)));
      check($sformatf("lap_pop%0d_count", k), 32'(o_lap_count), 32'(4 - k));
      pulse_pop();
      $display("lap pop %0d: count=%0d", k, o_lap_count);
      if (k == 0) check("lap_full_after_pop", 32'(o_lap_full), 32'd0);
    end
    check("lap_empty_count", 32'(o_lap_count), 32'd0);
    pulse_pop();
    check("lap_extra_pop", 32'(o_lap_count), 32'd0);

    // Clear beats load and runstop in the same cycle.
    pulse_clear();
    do_load(tm(0,0,10,0));
    pulse_runstop();
    cycles(15);
    pulse_lap();
    cycles(3);
    check("prio_pre_count", 32'(o_lap_count), 32'd1);
    i_clear = 1'b1; i_runstop = 1'b1; i_load = 1'b1; i_load_time = tm(1,1,1,1);
    @(negedge clk);
    i_clear = 1'b0; i_runstop = 1'b0; i_load = 1'b0;
    cycles(1);
    $display("priority: time=%06h running=%0d count=%0d", cur_time(), o_running, o_lap_count);
    check("prio_time",    32'(cur_time()),  32'd0);
    check("prio_running", 32'(o_running),   32'd0);
    check("prio_count",   32'(o_lap_count), 32'd0);
    cycles(30);
    check("prio_stopped", 32'(cur_time()), 32'd0);

    // A load while running is ignored; the tick in the same cycle still counts.
    do_load(tm(0,0,0,0));
    pulse_runstop();
    cycles(9);
    do_load(tm(1,2,3,4));
    $display("load in run: time=%06h", cur_time());
    check("ldrun_time1", 32'(cur_time()), 32'(tm(0,0,0,1)));
    cycles(10);
    check("ldrun_time2", 32'(cur_time()), 32'(tm(0,0,0,2)));
    check("ldrun_running", 32'(o_running), 32'd1);
    pulse_runstop();

    // Asynchronous reset mid-run with two laps held.
    pulse_clear();
    do_load(tm(0,0,0,0));
    pulse_runstop();
    cycles(12);
    pulse_lap();
    cycles(10);
    pulse_lap();
    cycles(10);
    check("rst_pre_count",   32'(o_lap_count), 32'd2);
    check("rst_pre_laptime", 32'(o_lap_time),  32'(tm(0,0,0,1)));
    check("rst_pre_time",    32'(cur_time()),  32'(tm(0,0,0,3)));
    check("rst_pre_running", 32'(o_running),   32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: time=%06h running=%0d count=%0d", cur_time(), o_running, o_lap_count);
    check("arst_time",    32'(cur_time()),  32'd0);
    check("arst_running", 32'(o_running),   32'd0);
    check("arst_count",   32'(o_lap_count), 32'd0);
    check("arst_full",    32'(o_lap_full),  32'd0);
    check("arst_laptime", 32'(o_lap_time),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    check("post_rst_running", 32'(o_running), 32'd0);
    pulse_runstop();
    cycles(10);
    check("post_rst_resume", 32'(cur_time()), 32'(tm(0,0,0,1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
